cache_fill_fsm: RTL

Cache miss fill controller for the pipelined 16-bit processor's I- and D-caches. On a miss it fetches the 16-byte block containing the miss address from the multi-cycle main memory as eight 16-bit words and streams each returned word into the cache data array. After the last word it issues the tag-array write. It sits between the cache hit/miss logic and the memory model, and stalls the pipeline while busy.

---
 rtl/cache_pkg.sv | 19 +
 rtl/fill_counter.sv | 27 ++
 rtl/cache_fill_fsm.sv | 119 +++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared types and block-geometry constants for the cache fill path.
package cache_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned WORDS       = BLOCK_BYTES / 2;
  localparam int unsigned OFFSET_BITS = $clog2(BLOCK_BYTES);
  localparam logic [15:0] BLOCK_MASK  = ~16'((1 << OFFSET_BITS) - 1);

  // Clears the byte-offset field of a block holding `words` 16-bit words.
  function automatic logic [15:0] block_mask(input int unsigned words);
    return ~(16'(2 * words) - 16'd1);
  endfunction

endpackage

// File: rtl/fill_counter.sv
// Saturating word counter for one side (issue or return) of a block fill.
module fill_counter #(
  parameter int unsigned WORDS = 8,
  parameter int unsigned CW    = $clog2(WORDS) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          done
);

  // Holds at WORDS so a stray increment can never wrap back to word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !done) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign done = (cnt == CW'(WORDS));

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: requests one block from memory as a pipelined
// burst of word reads and streams the returned words into the data array.
module cache_fill_fsm
  import cache_pkg::*;
#(
  parameter int unsigned WORDS = cache_pkg::WORDS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_detected,
  input  logic [15:0]              miss_address,
  input  logic                     memory_data_valid,
  input  logic [15:0]              memory_data,
  output logic                     fsm_busy,
  output logic                     mem_read_en,
  output logic [15:0]              memory_address,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic [15:0]              fill_data,
  output logic                     write_tag_array,
  output logic [15:0]              block_base
);

  localparam int unsigned IW = $clog2(WORDS);
  localparam int unsigned CW = IW + 1;
  localparam logic [15:0] BASE_MASK =
    (WORDS == cache_pkg::WORDS) ? BLOCK_MASK : block_mask(WORDS);

  state_t          state;
  state_t          state_next;
  logic [15:0]     base_q;
  logic [CW-1:0]   issue_cnt;
  logic [CW-1:0]   recv_cnt;
  logic            issue_done;
  logic            recv_done;
  logic            accept;
  logic            issue_inc;
  logic            recv_inc;

  fill_counter #(.WORDS(WORDS), .CW(CW)) u_issue (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (issue_inc),
    .clr   (accept),
    .cnt   (issue_cnt),
    .done  (issue_done)
  );

  fill_counter #(.WORDS(WORDS), .CW(CW)) u_recv (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (recv_inc),
    .clr   (accept),
    .cnt   (recv_cnt),
    .done  (recv_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
    end else if (accept) begin
      base_q <= miss_address & BASE_MASK;
    end
  end

  assign block_base = base_q;

  // Requests and returns run independently; the fill ends on the last return.
  always_comb begin
    state_next       = state;
    accept           = 1'b0;
    issue_inc        = 1'b0;
    recv_inc         = 1'b0;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;

    case (state)
      IDLE: begin
        if (miss_detected) begin
          accept     = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (!issue_done) begin
          mem_read_en    = 1'b1;
          memory_address = base_q + 16'({issue_cnt, 1'b0});
          issue_inc      = 1'b1;
        end
        if (memory_data_valid && !recv_done) begin
          write_data_array = 1'b1;
          fill_word        = recv_cnt[IW-1:0];
          fill_data        = memory_data;
          recv_inc         = 1'b1;
          if (recv_cnt == CW'(WORDS - 1)) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
